// File: rtl/dut_frame_arbiter.sv
// Frame-granular round-robin arbiter feeding a single registered valid/ready output slot.
// Optional idle-grant watchdog enabled by defining DUT_FRAME_ARBITER_TIMEOUT_EN.
`timescale 1ns/1ps
module dut_frame_arbiter #(
    parameter int NUM_INPUTS            = 4,
    parameter int DATA_WIDTH            = 36,
    parameter int IN_INTERFACE_ID_WIDTH = 2,
    parameter int TIMEOUT_CYCLES        = 16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0]     in_data,
    input  logic [NUM_INPUTS-1:0]                in_data_last,
    input  logic [NUM_INPUTS-1:0]                in_data_valid,
    output logic [NUM_INPUTS-1:0]                in_data_ready,
    output logic [DATA_WIDTH-1:0]                out_data,
    output logic [IN_INTERFACE_ID_WIDTH-1:0]     out_data_source_id,
    output logic                                 out_data_last,
    output logic                                 out_data_valid,
    input  logic                                 out_data_ready,
    output logic                                 timeout_err
);
    localparam int IDW = IN_INTERFACE_ID_WIDTH;

    if ((1 << IDW) < NUM_INPUTS || NUM_INPUTS < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("dut_frame_arbiter: inconsistent parameters");
    end

    // Handshake: a beat moves when valid and ready are both high at a rising edge;
    // valid never depends on ready, ready may depend on valid.
    typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]        grant_q, grant_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [IDW-1:0]        out_id_q, out_id_d;
    logic                  out_last_q, out_last_d;
    logic                  out_valid_q, out_valid_d;

    logic [NUM_INPUTS-1:0] rot_valid;
    logic                  win_found;
    int                    win_off;
    int                    win_sum;
    logic [IDW-1:0]        win_idx;
    logic [IDW-1:0]        sel_idx;
    logic                  sel_active;
    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  slot_free;
    logic                  accept;
    logic [IDW-1:0]        next_ptr;

    // Rotating the valid vector by rr_ptr turns the round-robin search into a priority search.
    always_comb begin
        rot_valid = NUM_INPUTS'({in_data_valid, in_data_valid} >> rr_ptr_q);
        win_found = 1'b0;
        win_off   = 0;
        for (int j = NUM_INPUTS - 1; j >= 0; j--) begin
            if (rot_valid[j]) begin
                win_found = 1'b1;
                win_off   = j;
            end
        end
        win_sum = int'(rr_ptr_q) + win_off;
        if (win_sum >= NUM_INPUTS) begin
            win_sum = win_sum - NUM_INPUTS;
        end
        win_idx = IDW'(win_sum);
    end

    always_comb begin
        sel_idx    = (state_q == ST_LOCKED) ? grant_q : win_idx;
        sel_active = (state_q == ST_LOCKED) || win_found;
        sel_valid  = 1'b0;
        sel_last   = 1'b0;
        sel_data   = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (sel_idx == IDW'(i)) begin
                sel_valid = in_data_valid[i];
                sel_last  = in_data_last[i];
                sel_data  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        slot_free = !out_valid_q || out_data_ready;
        accept    = sel_active && slot_free && sel_valid;
        next_ptr  = (sel_idx == IDW'(NUM_INPUTS - 1)) ? '0 : sel_idx + IDW'(1);
        // Ready is masked during reset so no beat appears taken while the frame is being abandoned.
        in_data_ready = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            in_data_ready[i] = sel_active && slot_free && !reset && (sel_idx == IDW'(i));
        end
    end

`ifdef DUT_FRAME_ARBITER_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TOW-1:0] to_cnt_q, to_cnt_d;
    logic           timeout_err_q, timeout_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            out_data_d  = sel_data;
            out_id_d    = sel_idx;
            out_last_d  = sel_last;
            out_valid_d = 1'b1;
            if (sel_last) begin
                state_d  = ST_IDLE;
                rr_ptr_d = next_ptr;
            end else if (state_q == ST_IDLE) begin
                state_d = ST_LOCKED;
                grant_d = sel_idx;
            end
        end else if (out_data_ready) begin
            out_valid_d = 1'b0;
        end
`ifdef DUT_FRAME_ARBITER_TIMEOUT_EN
        timeout_err_d = 1'b0;
        to_cnt_d      = '0;
        // Only cycles where the owner itself is silent count; a downstream stall keeps valid high.
        if (state_q == ST_LOCKED && !sel_valid) begin
            if (to_cnt_q == TOW'(TIMEOUT_CYCLES - 1)) begin
                state_d       = ST_IDLE;
                rr_ptr_d      = next_ptr;
                timeout_err_d = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + TOW'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef DUT_FRAME_ARBITER_TIMEOUT_EN
            to_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
`ifdef DUT_FRAME_ARBITER_TIMEOUT_EN
            to_cnt_q      <= to_cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign out_data           = out_data_q;
    assign out_data_source_id = out_id_q;
    assign out_data_last      = out_last_q;
    assign out_data_valid     = out_valid_q;
`ifdef DUT_FRAME_ARBITER_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_dut_frame_arbiter.sv
// Bench for dut_frame_arbiter: frame-level reference model, directed scenarios and random traffic.
`timescale 1ns/1ps
module tb_dut_frame_arbiter;
  localparam int N  = 4;
  localparam int DW = 36;
  localparam int IW = 2;
  localparam int TO = 16;
  localparam int EW = IW + 1 + DW;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [N*DW-1:0] in_data = '0;
  logic [N-1:0]    in_data_last = '0;
  logic [N-1:0]    in_data_valid = '0;
  logic [N-1:0]    in_data_ready;
  logic [DW-1:0]   out_data;
  logic [IW-1:0]   out_data_source_id;
  logic            out_data_last;
  logic            out_data_valid;
  logic            out_data_ready = 1'b0;
  logic            timeout_err;

  dut_frame_arbiter #(
    .NUM_INPUTS(N), .DATA_WIDTH(DW), .IN_INTERFACE_ID_WIDTH(IW), .TIMEOUT_CYCLES(TO)
  ) u_dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_data_last(in_data_last),
    .in_data_valid(in_data_valid), .in_data_ready(in_data_ready),
    .out_data(out_data), .out_data_source_id(out_data_source_id),
    .out_data_last(out_data_last), .out_data_valid(out_data_valid),
    .out_data_ready(out_data_ready), .timeout_err(timeout_err)
  );

  int tests = 0;
  int fails = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // source frame queues ({last,data}) and scoreboard ({id,last,data})
  logic [DW:0]   src_q[N][$];
  bit            held[N];
  logic [EW-1:0] exp_q[$];
  logic [IW-1:0] id_log[$];
  logic [DW-1:0] data_log[$];

  // reference model state, in frame-level terms
  bit m_locked = 0;
  int m_owner = 0;
  int m_ptr = 0;
  int m_to_cnt = 0;
  bit exp_to = 0;
  int to_seen = 0;
  int gate_pct = 100;
  int ready_pct = 100;

  function automatic int pending();
    int p;
    p = exp_q.size() + int'(m_locked);
    for (int i = 0; i < N; i++) p += src_q[i].size();
    return p;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (!held[i] && src_q[i].size() > 0 && $urandom_range(99) < gate_pct) held[i] = 1;
      in_data_valid[i] = held[i];
      if (held[i]) {in_data_last[i], in_data[i*DW +: DW]} = src_q[i][0];
      else begin
        in_data_last[i] = 1'($urandom_range(1));
        in_data[i*DW +: DW] = DW'({$urandom(), $urandom()});
      end
    end
    out_data_ready = ($urandom_range(99) < ready_pct);
  endtask

  task automatic step();
    logic [N-1:0]  exp_ready;
    logic [EW-1:0] beat;
    bit slot_free, act, acc;
    int sel;
    @(negedge clk);
    drive_inputs();
    #1;
    check_eq("timeout_err", timeout_err, exp_to);
    if (timeout_err) to_seen++;
    exp_to = 0;
    slot_free = (exp_q.size() == 0) || out_data_ready;
    act = 0;
    sel = 0;
    if (m_locked) begin
      act = 1;
      sel = m_owner;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!act && in_data_valid[(m_ptr + k) % N]) begin
          act = 1;
          sel = (m_ptr + k) % N;
        end
      end
    end
    exp_ready = (act && slot_free) ? (N'(1) << sel) : '0;
    check_eq("in_ready", in_data_ready, exp_ready);
    check_eq("out_valid", out_data_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check_eq("out_beat", {out_data_source_id, out_data_last, out_data}, exp_q[0]);
      if (out_data_ready) begin
        id_log.push_back(out_data_source_id);
        data_log.push_back(out_data);
        void'(exp_q.pop_front());
      end
    end
    acc = act && slot_free && in_data_valid[sel];
    if (acc) begin
      beat = {IW'(sel), src_q[sel][0]};
      exp_q.push_back(beat);
      void'(src_q[sel].pop_front());
      held[sel] = 0;
      m_to_cnt = 0;
      if (beat[DW]) begin
        m_locked = 0;
        m_ptr = (sel + 1) % N;
      end else if (!m_locked) begin
        m_locked = 1;
        m_owner = sel;
      end
    end
`ifdef DUT_FRAME_ARBITER_TIMEOUT_EN
    else if (m_locked) begin
      if (!in_data_valid[m_owner]) begin
        m_to_cnt++;
        if (m_to_cnt == TO) begin
          exp_to = 1;
          m_locked = 0;
          m_ptr = (m_owner + 1) % N;
          m_to_cnt = 0;
        end
      end else m_to_cnt = 0;
    end
`endif
  endtask

  task automatic drain(input int budget);
    for (int c = 0; c < budget; c++) begin
      if (pending() == 0) break;
      step();
    end
    check_eq("drain", pending(), 0);
  endtask

  // reset asserted between edges; frame in flight is abandoned on both sides
  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_eq("reset_outs", {out_data_valid, out_data_last, out_data_source_id, out_data,
                            in_data_ready, timeout_err}, 64'd0);
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      held[i] = 0;
    end
    m_locked = 0;
    m_ptr = 0;
    m_to_cnt = 0;
    exp_to = 0;
    in_data_valid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic push_frame(input int src, input int len, input logic [DW-1:0] base);
    for (int b = 0; b < len; b++) src_q[src].push_back({(b == len - 1), base + DW'(b)});
  endtask

  task automatic clear_logs();
    id_log.delete();
    data_log.delete();
  endtask

  initial begin
    int exp_ids[$];
    logic [DW-1:0] exp_dat[$];
    int total;

    do_reset();

    // single-beat frames from all sources rotate 0,1,2,3,0
    gate_pct = 100; ready_pct = 100; clear_logs();
    for (int i = 0; i < N; i++) push_frame(i, 1, DW'($urandom()));
    push_frame(0, 1, DW'($urandom()));
    drain(50);
    exp_ids = '{0, 1, 2, 3, 0};
    check_eq("rr_count", id_log.size(), 5);
    for (int j = 0; j < 5; j++) check_eq("rr_id", id_log[j], exp_ids[j]);

    // 3-beat frame from source 1 is not preempted by source 2
    clear_logs();
    push_frame(1, 3, 36'h11);
    push_frame(2, 1, 36'h21);
    drain(50);
    exp_ids = '{1, 1, 1, 2};
    exp_dat = '{36'h11, 36'h12, 36'h13, 36'h21};
    for (int j = 0; j < 4; j++) begin
      check_eq("lock_id", id_log[j], exp_ids[j]);
      check_eq("lock_data", data_log[j], exp_dat[j]);
    end

    // downstream stall for 5 cycles mid-frame
    clear_logs();
    push_frame(0, 4, 36'h30);
    push_frame(3, 1, 36'h3F);
    repeat (3) step();
    ready_pct = 0;
    repeat (5) step();
    ready_pct = 100;
    drain(50);
    exp_dat = '{36'h3F, 36'h30, 36'h31, 36'h32, 36'h33};
    check_eq("stall_count", data_log.size(), 5);
    for (int j = 0; j < 5; j++) check_eq("stall_data", data_log[j], exp_dat[j]);

    // pointer wraps from 3 to 0
    clear_logs();
    push_frame(3, 2, 36'h41);
    drain(50);
    push_frame(0, 1, 36'h50);
    push_frame(3, 1, 36'h51);
    drain(50);
    exp_ids = '{3, 3, 0, 3};
    for (int j = 0; j < 4; j++) check_eq("wrap_id", id_log[j], exp_ids[j]);

    // random traffic
    for (int r = 0; r < 6; r++) begin
      clear_logs();
      total = 0;
      gate_pct = $urandom_range(100, 40);
      ready_pct = $urandom_range(100, 40);
      for (int i = 0; i < N; i++) begin
        int nf;
        nf = $urandom_range(3, 1);
        for (int f = 0; f < nf; f++) begin
          int len;
          len = $urandom_range(4, 1);
          push_frame(i, len, DW'({$urandom(), $urandom()}));
          total += len;
        end
      end
      drain(3000);
      check_eq("rand_beats", data_log.size(), total);
    end

    // reset while source 2 holds the grant
    gate_pct = 100; ready_pct = 100;
    push_frame(2, 3, 36'h60);
    for (int c = 0; c < 10; c++) if (!m_locked) step();
    step();
    do_reset();
    clear_logs();
    push_frame(0, 1, 36'h70);
    push_frame(2, 1, 36'h72);
    drain(50);
    check_eq("post_reset_id", id_log[0], 0);
    check_eq("post_reset_data", data_log[0], 36'h70);

`ifdef DUT_FRAME_ARBITER_TIMEOUT_EN
    // source 0 abandons its frame after one beat; watchdog releases the grant
    do_reset();
    clear_logs();
    to_seen = 0;
    src_q[0].push_back({1'b0, 36'h80});
    push_frame(1, 1, 36'h81);
    drain(100);
    repeat (4) step();
    check_eq("to_pulses", to_seen, 1);
    exp_ids = '{0, 1};
    for (int j = 0; j < 2; j++) check_eq("to_id", id_log[j], exp_ids[j]);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dut_frame_arbiter.md
Name: dut_frame_arbiter

Overview:
- Shares one downstream multiply/pack path between NUM_INPUTS upstream requesters.
- Round-robin arbitration at frame granularity: once a source wins, it holds the grant until its beat with in_data_last is accepted.
- Output is a registered valid/ready interface carrying the winner's data, last flag and source ID; it feeds the math wrapper's input handshake directly.

Parameters:
- NUM_INPUTS, 4, number of requesting interfaces (2..16).
- DATA_WIDTH, 36, data width per interface.
- IN_INTERFACE_ID_WIDTH, 2, source-ID width; must satisfy 2**IN_INTERFACE_ID_WIDTH >= NUM_INPUTS.
- TIMEOUT_CYCLES, 16, idle-grant watchdog limit; used only with the optional feature.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous reset, active-high.
- in_data  input  NUM_INPUTS*DATA_WIDTH  per-source data; source i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- in_data_last  input  NUM_INPUTS  per-source last-beat-of-frame flag.
- in_data_valid  input  NUM_INPUTS  per-source valid.
- in_data_ready  output  NUM_INPUTS  per-source ready.
- out_data  output  DATA_WIDTH  registered data of the arbitrated source.
- out_data_source_id  output  IN_INTERFACE_ID_WIDTH  index of the source that supplied out_data.
- out_data_last  output  1  registered last flag.
- out_data_valid  output  1  output beat valid.
- out_data_ready  input  1  downstream ready.
- timeout_err  output  1  one-cycle pulse when a locked grant is force-released.

Behaviour:
- Reset (async assert, sync release): all outputs 0; state IDLE; rr_ptr = 0; grant_r = 0; out_data_valid = 0.
- Output slot:
  - Single register stage; slot_free = !out_data_valid || out_data_ready.
  - Input beat accepted when in_data_valid[g] && in_data_ready[g].
  - On acceptance, out_* load at the next edge; latency is 1 cycle, throughput 1 beat/cycle.
  - If out_data_valid && !out_data_ready, out_* hold stable.
  - out_data_valid clears only when out_data_ready && no new beat is accepted.
- Arbitration, state IDLE:
  - Winner g = first valid source at or after rr_ptr, modulo NUM_INPUTS.
  - in_data_ready[g] = slot_free; all other ready bits are 0.
  - If no source is valid, in_data_ready = 0.
  - Beat accepted with last=1: stay IDLE, rr_ptr <= g+1 (wraps NUM_INPUTS-1 -> 0).
  - Beat accepted with last=0: go to LOCKED, grant_r <= g.
  - No acceptance (slot busy): no state change; winner is recomputed next cycle.
- Arbitration, state LOCKED:
  - in_data_ready[grant_r] = slot_free; all other ready bits are 0.
  - Accepted beat with last=1: go to IDLE, rr_ptr <= grant_r+1 (wrapping).
  - Other sources' valid bits are ignored; no preemption.
- in_data_ready depends combinationally on out_data_ready and in_data_valid; no other combinational in->out paths.
- Source ID is the binary index of the winner, zero-extended to IN_INTERFACE_ID_WIDTH.
- Single-beat frames (last=1 on first beat) never enter LOCKED.
- Reset mid-frame: the frame is abandoned; the source must restart it. No partial state survives.
- Without the optional feature, timeout_err is tied 0.

Optional Feature:
- Macro: DUT_FRAME_ARBITER_TIMEOUT_EN.
- Enabled:
  - In LOCKED, a counter increments each cycle in_data_valid[grant_r] = 0 and clears on any valid cycle.
  - When the count reaches TIMEOUT_CYCLES: go to IDLE, rr_ptr <= grant_r+1, pulse timeout_err for 1 cycle. No beat is emitted.
  - Counter clears on entry to LOCKED and on reset.
  - Downstream stall (out_data_ready=0) does not count.
- Disabled: no counter is synthesized; a stalled source holds the grant indefinitely.

Test Plan:
- All 4 sources valid with single-beat frames, out_data_ready=1 -> out_data_source_id sequence 0,1,2,3,0 on consecutive cycles; first output 1 cycle after first accept.
- Source 1 sends 3-beat frame (data 0x11,0x12,0x13, last on 3rd) while source 2 is valid throughout -> output 0x11,0x12,0x13 with id=1; source 2 is first granted on the cycle after 0x13 is accepted.
- Downstream holds out_data_ready=0 for 5 cycles mid-frame -> out_* stable, in_data_ready all 0; resume produces no loss or duplication.
- Only source 3 valid, then sources 0 and 3 valid after its frame -> source 0 wins (pointer wrapped from 3 to 0).
- Assert reset during LOCKED on source 2 -> all outputs 0 immediately; after release, a source-0 request is granted first.
- With DUT_FRAME_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=16: source 0 sends 1 non-last beat then drops valid -> timeout_err pulses at idle cycle 16; source 1 is granted next.
